// File: rtl/mem_pkg.sv
// Shared encodings for the M-stage load/store front end.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  // Size 2'b11 falls into the word case.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic is_subword(input logic [1:0] size);
    is_subword = (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] ld_data;
  logic              stall;
  logic              misalign;
  logic              misalign_flag;
  logic [ADDR_W-1:0] bad_addr;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  ld_data, stall, misalign, misalign_flag, bad_addr
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output ld_data, stall, misalign, misalign_flag, bad_addr
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane extract/extend and lane merge for a 32-bit word.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] data,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{offset, 3'b000} +: 8];
    h      = offset[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = data;
    case (size)
      SZ_BYTE: begin
        ext    = {{24{~uns & b[7]}}, b};
        merged = word;
        merged[{offset, 3'b000} +: 8] = data[7:0];
      end
      SZ_HALF: begin
        ext    = {{16{~uns & h[15]}}, h};
        merged = word;
        merged[{offset[1], 4'b0000} +: 16] = data[15:0];
      end
      default: begin
        ext    = word;
        merged = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end over a word-only memory, with
// read-modify-write for sub-word stores and sticky misalign capture.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  mem_access_unit_if.slave  pipe,
  output logic              mwmem,
  output logic [ADDR_W-1:0] mr,
  output logic [DATA_W-1:0] mqb,
  input  logic [DATA_W-1:0] mdo
);

  state_e            state;
  logic [DATA_W-1:0] lat_word;
  logic [ADDR_W-1:0] lat_addr;
  logic              flag_q;
  logic [ADDR_W-1:0] bad_q;

  logic              mis;
  logic              rmw_start;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] st_merged;
  logic [DATA_W-1:0] ld_merged_unused;
  logic [DATA_W-1:0] st_ext_unused;
  logic              lint_unused;

  lane_align u_load (
    .word   (mdo),
    .offset (pipe.req_addr[1:0]),
    .size   (pipe.req_size),
    .uns    (pipe.req_unsigned),
    .data   ('0),
    .ext    (ld_ext),
    .merged (ld_merged_unused)
  );

  lane_align u_store (
    .word   (mdo),
    .offset (pipe.req_addr[1:0]),
    .size   (pipe.req_size),
    .uns    (1'b1),
    .data   (pipe.req_wdata),
    .ext    (st_ext_unused),
    .merged (st_merged)
  );

  assign lint_unused = ^{ld_merged_unused, st_ext_unused};

  assign word_addr = {pipe.req_addr[ADDR_W-1:2], 2'b00};
  assign mis       = (state == IDLE) && pipe.req_valid
                     && misaligned(pipe.req_size, pipe.req_addr[1:0]);
  assign rmw_start = (state == IDLE) && pipe.req_valid && pipe.req_we && !mis
                     && is_subword(pipe.req_size);

  // Memory strobes decode from state and inputs so an async reset kills a pending write.
  always_comb begin
    mwmem        = 1'b0;
    mr           = word_addr;
    mqb          = pipe.req_wdata;
    pipe.stall   = 1'b0;
    pipe.ld_data = '0;
    pipe.misalign = mis;
    if (state == RMW_WR) begin
      mwmem = 1'b1;
      mr    = lat_addr;
      mqb   = lat_word;
    end else if (pipe.req_valid && !mis) begin
      if (!pipe.req_we)      pipe.ld_data = ld_ext;
      else if (rmw_start)    pipe.stall   = 1'b1;
      else                   mwmem        = 1'b1;
    end
  end

  assign pipe.misalign_flag = flag_q;
  assign pipe.bad_addr      = bad_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      lat_word <= '0;
      lat_addr <= '0;
      flag_q   <= 1'b0;
      bad_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rmw_start) begin
            lat_word <= st_merged;
            lat_addr <= word_addr;
            state    <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (mis && !flag_q) begin
        flag_q <= 1'b1;
        bad_q  <= pipe.req_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a 4-word memory model.
module tb_mem_access_unit;
  logic        clk;
  logic        clrn;
  logic        mwmem;
  logic [31:0] mr;
  logic [31:0] mqb;
  logic [31:0] mdo;
  logic [31:0] mem [0:3];

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) pif ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .pipe  (pif),
    .mwmem (mwmem),
    .mr    (mr),
    .mqb   (mqb),
    .mdo   (mdo)
  );

  typedef struct {
    int           cyc;
    logic [95:0]  name;
    logic [31:0]  ld;
    logic         stall;
    logic         mw;
    logic [31:0]  mr;
    logic         chk_mr;
    logic [31:0]  mqb;
    logic         chk_mqb;
    logic         mis;
    logic         flag;
    logic [31:0]  bad;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mdo = mem[mr[3:2]];

  initial begin
    mem[0] = 32'hA00000AA;
    mem[1] = 32'h10000011;
    mem[2] = 32'h20000022;
    mem[3] = 32'h00000000;
    forever begin
      @(negedge clk);
      if (mwmem) mem[mr[3:2]] = mqb;
    end
  end

  task automatic cmp(input logic [95:0] nm, input logic [63:0] fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %0s.%0s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    pif.req_valid    = v;
    pif.req_we       = we;
    pif.req_size     = sz;
    pif.req_unsigned = uns;
    pif.req_addr     = addr;
    pif.req_wdata    = wd;
  endtask

  task automatic expect_r(input logic [95:0] nm, input logic [31:0] ld,
                          input logic st, input logic mw,
                          input logic cmr, input logic [31:0] emr,
                          input logic cmq, input logic [31:0] emq,
                          input logic mis, input logic fl, input logic [31:0] bad);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.ld = ld; e.stall = st; e.mw = mw;
    e.chk_mr = cmr; e.mr = emr; e.chk_mqb = cmq; e.mqb = emq;
    e.mis = mis; e.flag = fl; e.bad = bad;
    q.push_back(e);
  endtask

  // Monitor: samples mid-cycle, before the memory's negedge write.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #4;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL %0s.stale actual=cycle%0d required=cycle%0d", e.name, cyc, e.cyc);
        end else begin
          cmp(e.name, "ld_data", pif.ld_data, e.ld);
          cmp(e.name, "stall", {31'b0, pif.stall}, {31'b0, e.stall});
          cmp(e.name, "mwmem", {31'b0, mwmem}, {31'b0, e.mw});
          cmp(e.name, "misalign", {31'b0, pif.misalign}, {31'b0, e.mis});
          cmp(e.name, "mflag", {31'b0, pif.misalign_flag}, {31'b0, e.flag});
          cmp(e.name, "bad_addr", pif.bad_addr, e.bad);
          if (e.chk_mr)  cmp(e.name, "mr", mr, e.mr);
          if (e.chk_mqb) cmp(e.name, "mqb", mqb, e.mqb);
        end
      end
    end
  end

  initial begin
    clrn = 1'b0;
    pif.req_valid = 1'b0; pif.req_we = 1'b0; pif.req_size = 2'b00;
    pif.req_unsigned = 1'b0; pif.req_addr = '0; pif.req_wdata = '0;
    #22 clrn = 1'b1;

    drive(0, 0, 2'b00, 0, 32'h14, 32'h0);
    expect_r("reset_idle", 32'h0, 0, 0, 1, 32'h14, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 2'b00, 0, 32'h0, 32'h0);
    expect_r("lb_0", 32'hFFFFFFAA, 0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 2'b00, 1, 32'h4, 32'h0);
    expect_r("lbu_4", 32'h00000011, 0, 0, 1, 32'h4, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 2'b01, 0, 32'h2, 32'h0);
    expect_r("lh_2", 32'hFFFFA000, 0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 2'b01, 1, 32'h2, 32'h0);
    expect_r("lhu_2", 32'h0000A000, 0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);

    drive(1, 1, 2'b00, 0, 32'h9, 32'h5C);
    expect_r("sb_9_c0", 32'h0, 1, 0, 1, 32'h8, 0, 0, 0, 0, 32'h0);
    drive(1, 1, 2'b00, 0, 32'h9, 32'h5C);
    expect_r("sb_9_c1", 32'h0, 0, 1, 1, 32'h8, 1, 32'h20005C22, 0, 0, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h8, 32'h0);
    expect_r("lw_8", 32'h20005C22, 0, 0, 1, 32'h8, 0, 0, 0, 0, 32'h0);

    drive(1, 1, 2'b10, 0, 32'h4, 32'h12345678);
    expect_r("sw_4", 32'h0, 0, 1, 1, 32'h4, 1, 32'h12345678, 0, 0, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h4, 32'h0);
    expect_r("lw_4", 32'h12345678, 0, 0, 1, 32'h4, 0, 0, 0, 0, 32'h0);

    drive(1, 0, 2'b10, 0, 32'h6, 32'h0);
    expect_r("lw_6_mis", 32'h0, 0, 0, 1, 32'h4, 0, 0, 1, 0, 32'h0);
    drive(1, 1, 2'b01, 0, 32'h3, 32'hBEEF);
    expect_r("sh_3_mis", 32'h0, 0, 0, 1, 32'h0, 0, 0, 1, 1, 32'h6);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    expect_r("sticky", 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h6);

    // Back-to-back sub-word stores to the same word.
    drive(1, 1, 2'b00, 0, 32'hA, 32'h77);
    expect_r("sb_a_c0", 32'h0, 1, 0, 1, 32'h8, 0, 0, 0, 1, 32'h6);
    drive(1, 1, 2'b00, 0, 32'hA, 32'h77);
    expect_r("sb_a_c1", 32'h0, 0, 1, 1, 32'h8, 1, 32'h20775C22, 0, 1, 32'h6);
    drive(1, 1, 2'b01, 0, 32'h8, 32'h1234);
    expect_r("sh_8_c0", 32'h0, 1, 0, 1, 32'h8, 0, 0, 0, 1, 32'h6);
    drive(1, 1, 2'b01, 0, 32'h8, 32'h1234);
    expect_r("sh_8_c1", 32'h0, 0, 1, 1, 32'h8, 1, 32'h20771234, 0, 1, 32'h6);
    drive(1, 0, 2'b01, 0, 32'hA, 32'h0);
    expect_r("lh_a", 32'h00002077, 0, 0, 1, 32'h8, 0, 0, 0, 1, 32'h6);
    drive(1, 0, 2'b11, 0, 32'h8, 32'h0);
    expect_r("lw11_8", 32'h20771234, 0, 0, 1, 32'h8, 0, 0, 0, 1, 32'h6);

    // Reset pulse inside RMW_WR, with the pipeline flushing the request.
    drive(1, 1, 2'b01, 0, 32'h0, 32'h5555);
    expect_r("sh_0_c0", 32'h0, 1, 0, 1, 32'h0, 0, 0, 0, 1, 32'h6);
    drive(1, 1, 2'b01, 0, 32'h0, 32'h5555);
    #1;
    clrn = 1'b0;
    pif.req_valid = 1'b0;
    expect_r("rst_rmw", 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    #5 clrn = 1'b1;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    expect_r("post_rst", 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    cmp("rst_rmw", "word0", mem[0], 32'hA00000AA);
    drive(1, 0, 2'b10, 0, 32'h0, 32'h0);
    expect_r("lw_0", 32'hA00000AA, 0, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    drive(1, 1, 2'b00, 0, 32'h1, 32'h33);
    expect_r("sb_1_idle", 32'h0, 1, 0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain actual=%0d pending required=0 pending", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
